sfu_stream: RTL and testbench

//  Parametrised streaming successor to the project SFU. Sits between the OFIFO and the output SRAM.

---
 rtl/sfu_pkg.sv | 57 +++++
 rtl/sfu_lane.sv | 59 +++++
 rtl/sfu_stream.sv | 111 +++++++++++
 tb/tb_sfu_stream.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfu_pkg.sv
// Shared types and arithmetic helpers for the streaming SFU: mode encodings,
// sign extension, activation and saturation on a wide signed working word.
package sfu_pkg;

    typedef enum logic [1:0] {
        SFU_MODE_BYPASS = 2'b00,
        SFU_MODE_RELU   = 2'b01,
        SFU_MODE_LEAKY  = 2'b10,
        SFU_MODE_RELU_B = 2'b11
    } sfu_mode_e;

    // All lane arithmetic is done on this width; psum_bw and acc_bw must not exceed it.
    localparam int unsigned SFU_MAXW = 64;

    typedef logic signed [SFU_MAXW-1:0] sfu_word_t;

    // Sign-extend the low bw bits of x to the full working width.
    function automatic sfu_word_t sfu_sext(input logic [SFU_MAXW-1:0] x, input int unsigned bw);
        sfu_word_t t;
        t = x << (SFU_MAXW - bw);
        return t >>> (SFU_MAXW - bw);
    endfunction

    function automatic sfu_word_t sfu_activate(input sfu_word_t x, input sfu_mode_e mode,
                                               input logic [2:0] shift);
        if (!x[SFU_MAXW-1] || mode == SFU_MODE_BYPASS) begin
            return x;
        end
        if (mode == SFU_MODE_LEAKY) begin
            return x >>> shift;
        end
        return '0;
    endfunction

    function automatic sfu_word_t sfu_saturate(input sfu_word_t x, input int unsigned bw);
        sfu_word_t hi;
        sfu_word_t lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic sfu_clips(input sfu_word_t x, input int unsigned bw);
        sfu_word_t hi;
        sfu_word_t lo;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/sfu_lane.sv
// One output channel: widened accumulator plus activation/saturation feeding
// the lane's slice of the output register.
module sfu_lane
    import sfu_pkg::*;
#(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned acc_bw  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               beat,
    input  logic               first,
    input  logic               last,
    input  sfu_mode_e          mode,
    input  logic [2:0]         shift,
    input  logic [psum_bw-1:0] psum,
    output logic [psum_bw-1:0] res,
    output logic               sat
);

    logic [acc_bw-1:0]  acc_q;
    logic [acc_bw-1:0]  sum;
    sfu_word_t          act;
    logic [psum_bw-1:0] res_d;
    logic               sat_d;

    // The first beat of a set overwrites the accumulator, so no clear cycle is needed.
    always_comb begin
        sum   = acc_bw'(sfu_sext(SFU_MAXW'(psum), psum_bw));
        if (!first) begin
            sum = acc_q + sum;
        end
        act   = sfu_activate(sfu_sext(SFU_MAXW'(sum), acc_bw), mode, shift);
        res_d = psum_bw'(sfu_saturate(act, psum_bw));
        sat_d = sfu_clips(act, psum_bw);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (beat) begin
            acc_q <= sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res <= '0;
            sat <= 1'b0;
        end else if (beat && last) begin
            res <= res_d;
            sat <= sat_d;
        end
    end

endmodule

// File: rtl/sfu_stream.sv
// Streaming SFU top: beat counter, per-set config latch and valid/ready handshakes
// around col accumulate-activate-saturate lanes.
module sfu_stream
    import sfu_pkg::*;
#(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned acc_bw  = 20,
    parameter int unsigned col     = 8,
    parameter int unsigned cnt_bw  = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [cnt_bw-1:0]      cfg_nacc,
    input  logic [1:0]             cfg_mode,
    input  logic [2:0]             cfg_shift,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [psum_bw*col-1:0] psum_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [psum_bw*col-1:0] sfp_out,
    output logic [col-1:0]         out_sat,
    output logic                   busy
);

    logic [cnt_bw-1:0] count_q;
    logic [cnt_bw-1:0] nacc_q;
    sfu_mode_e         mode_q;
    logic [2:0]        shift_q;
    logic              out_valid_q;

    logic [cnt_bw-1:0] nacc_eff;
    sfu_mode_e         mode_eff;
    logic [2:0]        shift_eff;
    logic              first;
    logic              last;
    logic              accept;
    logic              done;

    // On the first beat the live cfg_* inputs apply, so a one-beat set needs no latched copy.
    always_comb begin
        first     = (count_q == '0);
        nacc_eff  = first ? cfg_nacc : nacc_q;
        if (nacc_eff == '0) begin
            nacc_eff = cnt_bw'(1);
        end
        mode_eff  = first ? sfu_mode_e'(cfg_mode) : mode_q;
        shift_eff = first ? cfg_shift : shift_q;
        last      = (count_q == nacc_eff - cnt_bw'(1));
        // Only a completing beat needs the output register free.
        in_ready  = !(last && out_valid_q && !out_ready);
        accept    = in_valid && in_ready && !clear;
        done      = accept && last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= done ? '0 : count_q + cnt_bw'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nacc_q  <= '0;
            mode_q  <= SFU_MODE_BYPASS;
            shift_q <= '0;
        end else if (accept && first) begin
            nacc_q  <= nacc_eff;
            mode_q  <= mode_eff;
            shift_q <= shift_eff;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
        end else if (done) begin
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (count_q != '0);

    for (genvar g = 0; g < int'(col); g++) begin : g_lane
        sfu_lane #(
            .psum_bw (psum_bw),
            .acc_bw  (acc_bw)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .beat  (accept),
            .first (first),
            .last  (last),
            .mode  (mode_eff),
            .shift (shift_eff),
            .psum  (psum_in[psum_bw*g +: psum_bw]),
            .res   (sfp_out[psum_bw*g +: psum_bw]),
            .sat   (out_sat[g])
        );
    end

endmodule

// File: tb/tb_sfu_stream.sv
// Directed and randomized bench for sfu_stream against a set-level arithmetic model.
module tb_sfu_stream;

    localparam int PB  = 16;
    localparam int AB  = 20;
    localparam int COL = 8;
    localparam int CB  = 6;
    localparam int W   = PB * COL;

    logic            clk = 1'b0;
    logic            reset;
    logic            clear;
    logic [CB-1:0]   cfg_nacc;
    logic [1:0]      cfg_mode;
    logic [2:0]      cfg_shift;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    psum_in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    sfp_out;
    logic [COL-1:0]  out_sat;
    logic            busy;

    sfu_stream #(
        .psum_bw (PB),
        .acc_bw  (AB),
        .col     (COL),
        .cnt_bw  (CB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .cfg_nacc  (cfg_nacc),
        .cfg_mode  (cfg_mode),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .psum_in   (psum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sfp_out   (sfp_out),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   data;
        logic [COL-1:0] sat;
    } res_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_sum[COL];
    int     m_cnt, m_nacc, m_mode, m_shift;
    res_t   exp_q[$];
    logic signed [PB-1:0] beat_v[COL];
    bit     last_acc;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wrap the set total to the accumulator width, activate, then clip to the output width.
    function automatic res_t finish_set();
        res_t   r;
        longint x;
        longint hi = (longint'(1) <<< (PB - 1)) - 1;
        longint lo = -(longint'(1) <<< (PB - 1));
        for (int g = 0; g < COL; g++) begin
            x = m_sum[g] & ((longint'(1) <<< AB) - 1);
            if (x >= (longint'(1) <<< (AB - 1))) x = x - (longint'(1) <<< AB);
            if (x < 0) begin
                if (m_mode == 2) x = x >>> m_shift;
                else if (m_mode != 0) x = 0;
            end
            r.sat[g] = 1'b0;
            if (x > hi) begin x = hi; r.sat[g] = 1'b1; end
            else if (x < lo) begin x = lo; r.sat[g] = 1'b1; end
            r.data[g*PB +: PB] = PB'(x);
        end
        return r;
    endfunction

    // One clock: check outputs, predict acceptance, advance the model, step to next negedge.
    task automatic cycle();
        int eff;
        bit rdy;
        bit acc;
        #1;
        check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("sfp_out", sfp_out, exp_q[0].data);
            check("out_sat", W'(out_sat), W'(exp_q[0].sat));
        end
        check("busy", W'(busy), W'(m_cnt != 0));
        eff = (m_cnt == 0) ? ((cfg_nacc == 0) ? 1 : int'(cfg_nacc)) : m_nacc;
        rdy = !((m_cnt == eff - 1) && exp_q.size() > 0 && !out_ready);
        check("in_ready", W'(in_ready), W'(rdy));
        acc = in_valid && rdy && !clear;
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (clear) begin
            m_cnt = 0;
        end else if (acc) begin
            if (m_cnt == 0) begin
                m_nacc = eff; m_mode = int'(cfg_mode); m_shift = int'(cfg_shift);
                for (int g = 0; g < COL; g++) m_sum[g] = longint'(beat_v[g]);
            end else begin
                for (int g = 0; g < COL; g++) m_sum[g] += longint'(beat_v[g]);
            end
            m_cnt++;
            if (m_cnt == m_nacc) begin
                exp_q.push_back(finish_set());
                m_cnt = 0;
            end
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_beat();
        for (int g = 0; g < COL; g++) psum_in[g*PB +: PB] = beat_v[g];
    endtask

    task automatic set3(input int a, input int b, input int c);
        for (int g = 0; g < COL; g++) beat_v[g] = '0;
        beat_v[0] = PB'(a);
        beat_v[1] = PB'(b);
        beat_v[2] = PB'(c);
    endtask

    task automatic send_beat();
        int tries = 0;
        drive_beat();
        in_valid = 1'b1;
        do begin
            cycle();
            tries++;
        end while (!last_acc && tries < 40);
        n_checks++;
        assert (last_acc) else begin
            n_fail++;
            $error("FAIL accept_timeout: observed no accept expected accept within 40 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_sfp_out", sfp_out, '0);
        check("rst_out_sat", W'(out_sat), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; psum_in = '0;
        cfg_nacc = '0; cfg_mode = '0; cfg_shift = '0;
        m_cnt = 0; m_nacc = 1; m_mode = 0; m_shift = 0; last_acc = 1'b0;
        for (int g = 0; g < COL; g++) begin beat_v[g] = '0; m_sum[g] = 0; end
        @(negedge clk);
        do_reset();

        // 1: nacc=3 ReLU
        cfg_nacc = 6'd3; cfg_mode = 2'b01;
        set3(5, -5, 0);  send_beat();
        set3(-2, -2, 0); send_beat();
        set3(4, 1, 0);   send_beat();
        check("t1_valid", W'(out_valid), W'(1'b1));
        check("t1_lane0", W'(sfp_out[15:0]), W'(16'd7));
        check("t1_lane1", W'(sfp_out[31:16]), W'(16'd0));
        cycle();

        // 2: nacc=1 leaky shift 2
        cfg_nacc = 6'd1; cfg_mode = 2'b10; cfg_shift = 3'd2;
        set3(-16, -3, 9); send_beat();
        check("t2_lane0", W'(sfp_out[15:0]), W'(16'hFFFC));
        check("t2_lane1", W'(sfp_out[31:16]), W'(16'hFFFF));
        check("t2_lane2", W'(sfp_out[47:32]), W'(16'd9));
        cycle();

        // 3: nacc=4 bypass saturation
        cfg_nacc = 6'd4; cfg_mode = 2'b00; cfg_shift = 3'd0;
        for (int i = 0; i < 4; i++) begin set3(28672, -28672, 0); send_beat(); end
        check("t3_lane0", W'(sfp_out[15:0]), W'(16'h7FFF));
        check("t3_lane1", W'(sfp_out[31:16]), W'(16'h8000));
        check("t3_sat", W'(out_sat), W'(8'b0000_0011));
        cycle();

        // 4: back-pressure across two sets of two
        cfg_nacc = 6'd2; out_ready = 1'b0;
        set3(100, 7, 0); send_beat();
        set3(200, 8, 0); send_beat();
        set3(1, 9, 0);   send_beat();
        set3(2, 10, 0);  drive_beat(); in_valid = 1'b1;
        #1;
        check("t4_stall", W'(in_ready), W'(1'b0));
        check("t4_a_held", W'(sfp_out[15:0]), W'(16'd300));
        cycle(); cycle();
        out_ready = 1'b1;
        send_beat();
        check("t4_b_valid", W'(out_valid), W'(1'b1));
        check("t4_b_lane0", W'(sfp_out[15:0]), W'(16'd3));
        check("t4_b_lane1", W'(sfp_out[31:16]), W'(16'd19));
        cycle(); cycle();

        // 5: reset, then clear, part-way through a set of three
        cfg_nacc = 6'd3; cfg_mode = 2'b00;
        set3(10, 20, 30); send_beat(); send_beat();
        do_reset();
        set3(1, 1, 1); send_beat();
        set3(2, 2, 2); send_beat();
        set3(3, 3, 3); send_beat();
        check("t5_reset_sum", W'(sfp_out[15:0]), W'(16'd6));
        set3(10, 20, 30); send_beat(); send_beat();
        set3(50, 50, 50); drive_beat(); in_valid = 1'b1; clear = 1'b1;
        cycle();
        clear = 1'b0; in_valid = 1'b0;
        check("t5_clear_busy", W'(busy), '0);
        set3(1, 1, 1); send_beat();
        set3(2, 2, 2); send_beat();
        set3(3, 3, 3); send_beat();
        check("t5_clear_sum", W'(sfp_out[31:16]), W'(16'd6));
        cycle();

        // 6: nacc=0 means one beat per output; mid-set nacc change is ignored
        cfg_nacc = 6'd0;
        set3(11, 0, 0); send_beat();
        check("t6_n0_a", W'(sfp_out[15:0]), W'(16'd11));
        set3(12, 0, 0); send_beat();
        check("t6_n0_b", W'(sfp_out[15:0]), W'(16'd12));
        cfg_nacc = 6'd2;
        set3(5, 0, 0); send_beat();
        cfg_nacc = 6'd5;
        set3(6, 0, 0); send_beat();
        check("t6_latched", W'(out_valid), W'(1'b1));
        check("t6_sum", W'(sfp_out[15:0]), W'(16'd11));
        cycle();

        // Randomized traffic with random back-pressure, config churn and rare clears
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 49) == 0);
            cfg_nacc  = CB'($urandom_range(0, 4));
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_shift = 3'($urandom_range(0, 7));
            for (int g = 0; g < COL; g++) beat_v[g] = PB'($urandom);
            drive_beat();
            cycle();
        end
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
